// File: rtl/bus_port_arbiter.sv
// Round-robin owner of the shared 8-bit pin bus: arbitrates two 32-bit requesters
// and serialises each granted access as address bytes, a command byte, then data bytes.
module bus_port_arbiter #(
  parameter int ADDR_BYTES = 4,
  parameter int DATA_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        gnt0,
  output logic        done0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        gnt1,
  output logic        done1,
  output logic [31:0] rdata,
  output logic [7:0]  pin_out,
  output logic [7:0]  io_out,
  input  logic [7:0]  io_in,
  output logic [7:0]  io_oe,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, ADDR, CMD, DATA, DONE} state_t;

  localparam logic [1:0] ADDR_LAST = 2'(ADDR_BYTES - 1);
  localparam logic [1:0] DATA_LAST = 2'(DATA_BYTES - 1);

  state_t      state_reg;
  logic [1:0]  idx_reg;
  logic [1:0]  idx_inc;
  logic        last_grant_reg;
  logic        gid_reg;
  logic        we_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rd_buf_reg;
  logic [31:0] rd_merged;
  logic        pick1;

  assign idx_inc = idx_reg + 2'd1;

  // Requester 1 wins when it is alone, or on a tie when requester 0 had the last grant.
  assign pick1 = req1 & (~req0 | ~last_grant_reg);

  // Read buffer with the current io_in byte dropped into lane idx_reg.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rd_lane
      assign rd_merged[8*gi +: 8] = (idx_reg == 2'(gi)) ? io_in : rd_buf_reg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      idx_reg        <= 2'd0;
      last_grant_reg <= 1'b1;
      gid_reg        <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      rd_buf_reg     <= '0;
      gnt0           <= 1'b0;
      gnt1           <= 1'b0;
      done0          <= 1'b0;
      done1          <= 1'b0;
      rdata          <= '0;
      pin_out        <= '0;
      io_out         <= '0;
      io_oe          <= '0;
      busy           <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req0 | req1) begin
            state_reg      <= ADDR;
            idx_reg        <= 2'd0;
            busy           <= 1'b1;
            gid_reg        <= pick1;
            last_grant_reg <= pick1;
            gnt0           <= ~pick1;
            gnt1           <= pick1;
            we_reg         <= pick1 ? we1 : we0;
            addr_reg       <= pick1 ? addr1 : addr0;
            wdata_reg      <= pick1 ? wdata1 : wdata0;
            rd_buf_reg     <= '0;
            pin_out        <= pick1 ? addr1[7:0] : addr0[7:0];
          end
        end
        ADDR: begin
          if (idx_reg == ADDR_LAST) begin
            state_reg <= CMD;
            idx_reg   <= 2'd0;
            pin_out   <= {6'b0, gid_reg, we_reg};
          end else begin
            idx_reg <= idx_inc;
            pin_out <= addr_reg[{idx_inc, 3'b000} +: 8];
          end
        end
        CMD: begin
          state_reg <= DATA;
          idx_reg   <= 2'd0;
          pin_out   <= '0;
          io_oe     <= {8{we_reg}};
          io_out    <= we_reg ? wdata_reg[7:0] : 8'h00;
        end
        DATA: begin
          if (!we_reg) rd_buf_reg <= rd_merged;
          if (idx_reg == DATA_LAST) begin
            state_reg <= DONE;
            idx_reg   <= 2'd0;
            io_oe     <= '0;
            io_out    <= '0;
            done0     <= ~gid_reg;
            done1     <= gid_reg;
            // rdata only moves when a read completes, so it holds across write frames.
            if (!we_reg) rdata <= rd_merged;
          end else begin
            idx_reg <= idx_inc;
            if (we_reg) io_out <= wdata_reg[{idx_inc, 3'b000} +: 8];
          end
        end
        DONE: begin
          state_reg <= IDLE;
          gnt0      <= 1'b0;
          gnt1      <= 1'b0;
          done0     <= 1'b0;
          done1     <= 1'b0;
          busy      <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_port_arbiter.sv
// Bench for bus_port_arbiter: frame-level reference model checked every cycle,
// plus directed literal checks, and a second instance built with 2 address / 1 data byte.
module tb_bus_port_arbiter;
  localparam int AB = 4;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [31:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
  logic [7:0]  io_in = 0;
  logic        gnt0, done0, gnt1, done1, busy;
  logic [31:0] rdata;
  logic [7:0]  pin_out, io_out, io_oe;

  logic        s_req0 = 0, s_we0 = 0, s_req1 = 0, s_we1 = 0;
  logic [31:0] s_addr0 = 0, s_wdata0 = 0, s_addr1 = 0, s_wdata1 = 0;
  logic [7:0]  s_io_in = 0;
  logic        s_gnt0, s_done0, s_gnt1, s_done1, s_busy;
  logic [31:0] s_rdata;
  logic [7:0]  s_pin_out, s_io_out, s_io_oe;

  bus_port_arbiter #(.ADDR_BYTES(AB), .DATA_BYTES(DB)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1),
    .rdata(rdata), .pin_out(pin_out), .io_out(io_out), .io_in(io_in), .io_oe(io_oe),
    .busy(busy)
  );

  bus_port_arbiter #(.ADDR_BYTES(2), .DATA_BYTES(1)) u_dut_small (
    .clk(clk), .rst(rst),
    .req0(s_req0), .we0(s_we0), .addr0(s_addr0), .wdata0(s_wdata0), .gnt0(s_gnt0), .done0(s_done0),
    .req1(s_req1), .we1(s_we1), .addr1(s_addr1), .wdata1(s_wdata1), .gnt1(s_gnt1), .done1(s_done1),
    .rdata(s_rdata), .pin_out(s_pin_out), .io_out(s_io_out), .io_in(s_io_in), .io_oe(s_io_oe),
    .busy(s_busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  // phase: 0 idle, 1 address, 2 command, 3 data, 4 done
  typedef struct {
    int         phase;
    int         k;
    logic       we;
    logic [7:0] pin, oe, out;
    logic       g0, g1, d0, d1, bsy;
  } vec_t;

  vec_t        m_cur;
  vec_t        m_q[$];
  logic        m_last;
  logic [31:0] m_rdata, m_acc;

  function automatic vec_t idle_vec();
    vec_t v;
    v.phase = 0; v.k = 0; v.we = 0;
    v.pin = 0; v.oe = 0; v.out = 0;
    v.g0 = 0; v.g1 = 0; v.d0 = 0; v.d1 = 0; v.bsy = 0;
    return v;
  endfunction

  function automatic vec_t mk(int phase, int k, logic we, logic gid,
                              logic [7:0] pin, logic [7:0] oe, logic [7:0] out);
    vec_t v;
    v.phase = phase; v.k = k; v.we = we;
    v.pin = pin; v.oe = oe; v.out = out;
    v.g0 = !gid; v.g1 = gid;
    v.d0 = (phase == 4) && !gid;
    v.d1 = (phase == 4) && gid;
    v.bsy = 1'b1;
    return v;
  endfunction

  initial begin
    logic        w, we;
    logic [31:0] a, d;
    m_cur = idle_vec(); m_last = 1'b1; m_rdata = 0; m_acc = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_q.delete(); m_cur = idle_vec(); m_last = 1'b1; m_rdata = 0; m_acc = 0;
      end else begin
        if (m_cur.phase == 3 && !m_cur.we) begin
          m_acc[8*m_cur.k +: 8] = io_in;
          if (m_cur.k == DB - 1) m_rdata = m_acc;
        end
        if (m_q.size() > 0) begin
          m_cur = m_q.pop_front();
        end else if (m_cur.phase == 0 && (req0 || req1)) begin
          w = (req0 && req1) ? !m_last : req1;
          m_last = w;
          a  = w ? addr1 : addr0;
          d  = w ? wdata1 : wdata0;
          we = w ? we1 : we0;
          m_acc = 0;
          for (int k = 0; k < AB; k++) m_q.push_back(mk(1, k, we, w, 8'(a >> (8*k)), 8'h00, 8'h00));
          m_q.push_back(mk(2, 0, we, w, {6'b0, w, we}, 8'h00, 8'h00));
          for (int k = 0; k < DB; k++)
            m_q.push_back(mk(3, k, we, w, 8'h00, we ? 8'hFF : 8'h00, we ? 8'(d >> (8*k)) : 8'h00));
          m_q.push_back(mk(4, 0, we, w, 8'h00, 8'h00, 8'h00));
          m_cur = m_q.pop_front();
        end else begin
          m_cur = idle_vec();
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("pin_out", pin_out, m_cur.pin);
        check("io_oe", io_oe, m_cur.oe);
        check("io_out", io_out, m_cur.out);
        check("gnt0", gnt0, m_cur.g0);
        check("gnt1", gnt1, m_cur.g1);
        check("done0", done0, m_cur.d0);
        check("done1", done1, m_cur.d1);
        check("busy", busy, m_cur.bsy);
        if (m_cur.phase == 0 || m_cur.phase == 4) check("rdata", rdata, m_rdata);
        if (done0 || done1) $display("frame done: port %0d rdata=%h t=%0t", done1, rdata, $time);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_gnt(input logic which, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(which ? gnt1 : gnt0) && n < 30);
    check(name, which ? gnt1 : gnt0, 1'b1);
  endtask

  task automatic wait_done(input logic which, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(which ? done1 : done0) && n < 30);
    check(name, which ? done1 : done0, 1'b1);
  endtask

  logic [7:0] t1_pin [4];
  logic [7:0] t1_dat [4];
  logic [7:0] t2_in  [4];
  logic [7:0] t5_pin [4];
  int         order  [4];

  initial begin
    int n, cyc, dn;
    t1_pin = '{8'h44, 8'h33, 8'h22, 8'h11};
    t1_dat = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    t2_in  = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    t5_pin = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};

    // reset state
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_pin", pin_out, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_gnt", {gnt1, gnt0}, 2'b00);
    check("rst_oe", io_oe, 8'h00);
    check("rst_rdata", rdata, 32'h0);
    #1 rst = 1'b0;

    // write from port 0
    req0 = 1; we0 = 1; addr0 = 32'h11223344; wdata0 = 32'hA1B2C3D4;
    wait_gnt(0, "t1_gnt0");
    check("t1_addr", pin_out, t1_pin[0]);
    for (int k = 1; k < 4; k++) begin @(negedge clk); check("t1_addr", pin_out, t1_pin[k]); end
    @(negedge clk); check("t1_cmd", pin_out, 8'h01);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t1_oe", io_oe, 8'hFF);
      check("t1_data", io_out, t1_dat[k]);
    end
    @(negedge clk); check("t1_done0", done0, 1'b1);
    #1 req0 = 0;

    // read from port 1
    req1 = 1; we1 = 0; addr1 = 32'h00000080;
    wait_gnt(1, "t2_gnt1");
    check("t2_addr0", pin_out, 8'h80);
    repeat (3) @(negedge clk);
    @(negedge clk); check("t2_cmd", pin_out, 8'h02);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t2_oe", io_oe, 8'h00);
      #1 io_in = t2_in[k];
    end
    @(negedge clk);
    check("t2_done1", done1, 1'b1);
    check("t2_rdata", rdata, 32'h8D7C6B5A);
    #1 req1 = 0; io_in = 0;
    repeat (3) @(negedge clk);
    check("t2_rdata_held", rdata, 32'h8D7C6B5A);

    // both requesters held: alternating grants
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    req0 = 1; we0 = 1; addr0 = 32'h0000A0A0; wdata0 = 32'h01010101;
    req1 = 1; we1 = 1; addr1 = 32'h0000B1B1; wdata1 = 32'h02020202;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (done0 || done1) begin
        order[n] = done1 ? 1 : 0;
        n++;
      end
    end
    #1 req0 = 0; req1 = 0;
    check("t3_frames", n, 4);
    for (int i = 0; i < n; i++) check("t3_order", order[i], i % 2);

    // asynchronous reset in the middle of a write's data phase
    req0 = 1; we0 = 1; addr0 = 32'h01020304; wdata0 = 32'h55AA55AA;
    wait_gnt(0, "t4_gnt0");
    repeat (5) @(negedge clk);
    @(negedge clk);
    check("t4_data1_oe", io_oe, 8'hFF);
    #2 rst = 1'b1;
    #1;
    check("t4_async_pin", pin_out, 8'h00);
    check("t4_async_oe", io_oe, 8'h00);
    check("t4_async_out", io_out, 8'h00);
    check("t4_async_gnt", {gnt1, gnt0}, 2'b00);
    check("t4_async_busy", busy, 1'b0);
    check("t4_async_done", {done1, done0}, 2'b00);
    @(negedge clk);
    #1 rst = 1'b0;
    wait_gnt(0, "t4_restart_gnt0");
    check("t4_restart_addr", pin_out, 8'h04);
    wait_done(0, "t4_restart_done0");
    #1 req0 = 0;

    // single-cycle request, address changed during the frame
    req0 = 1; we0 = 1; addr0 = 32'hCAFEF00D; wdata0 = 32'h12345678;
    wait_gnt(0, "t5_gnt0");
    check("t5_addr", pin_out, t5_pin[0]);
    #1 req0 = 0; addr0 = 32'hDEADBEEF; wdata0 = 32'hFFFFFFFF;
    for (int k = 1; k < 4; k++) begin @(negedge clk); check("t5_addr", pin_out, t5_pin[k]); end
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (done0) dn++;
    end
    check("t5_done_count", dn, 1);

    // small build: 2 address bytes, 1 data byte, read from port 0
    #1 s_req0 = 1; s_we0 = 0; s_addr0 = 32'h0000BEEF;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_gnt0 && n < 30);
    check("s_gnt0", s_gnt0, 1'b1);
    check("s_addr0", s_pin_out, 8'hEF);
    @(negedge clk); check("s_addr1", s_pin_out, 8'hBE);
    @(negedge clk); check("s_cmd", s_pin_out, 8'h00); check("s_busy", s_busy, 1'b1);
    @(negedge clk);
    check("s_data_oe", s_io_oe, 8'h00);
    check("s_data_nodone", s_done0, 1'b0);
    #1 s_io_in = 8'hC3;
    @(negedge clk);
    check("s_done0", s_done0, 1'b1);
    check("s_rdata", s_rdata, 32'h000000C3);
    check("s_rdata_upper", s_rdata[31:8], 24'h0);
    #1 s_req0 = 0; s_io_in = 0;
    @(negedge clk);
    check("s_idle_busy", s_busy, 1'b0);
    check("s_idle_done", s_done0, 1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t, limit 200000", $time);
    $fatal(1);
  end

endmodule
